// File: rtl/int_to_fp_seq_pkg.sv
// Format constants for the 8-bit integer <-> 13-bit {sign, exp, frac} fp pair,
// shared by int_to_fp_seq and fp_to_int.
package int_to_fp_seq_pkg;

  localparam int FP_W     = 13;
  localparam int EXP_W    = 4;
  localparam int FRAC_W   = 8;
  localparam int INT_W    = 8;

  localparam int SIGN_BIT = 12;
  localparam int EXP_MSB  = 11;
  localparam int EXP_LSB  = 8;
  localparam int FRAC_MSB = 7;
  localparam int FRAC_LSB = 0;

  localparam logic [FP_W-1:0]  FP_ZERO  = 13'h0000;
  localparam logic [EXP_W-1:0] EXP_INIT = 4'd8;

endpackage

// File: rtl/int_to_fp_seq.sv
// Sequential signed 8-bit integer to {sign, exp[3:0], frac[7:0]} converter.
// Normalizes one left shift per clock under a start/ready/done_tick handshake.
module int_to_fp_seq
  import int_to_fp_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [INT_W-1:0]  int_in,
  output logic              ready,
  output logic              done_tick,
  output logic [FP_W-1:0]   fp_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [INT_W-1:0]  int_s;
  logic                     sign_r;
  logic [FRAC_W-1:0]        mag_r;
  logic [EXP_W-1:0]         exp_r;
  logic                     capture;
  logic                     shift;
  logic                     finish;

  // -128 maps to 8'h80, which is exactly representable as an unsigned magnitude.
  function automatic logic [INT_W-1:0] abs_mag(input logic signed [INT_W-1:0] v);
    logic [INT_W-1:0] u;
    u = v;
    abs_mag = v[INT_W-1] ? (~u + 1'b1) : u;
  endfunction

  assign int_s = int_in;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done_tick = 1'b0;
    capture   = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          capture   = 1'b1;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (mag_r[FRAC_W-1] || (mag_r == '0)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          shift = 1'b1;
        end
      end
      DONE: begin
        done_tick = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result register: reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      fp_out <= FP_ZERO;
    end else begin
      state <= state_nxt;
      if (finish)
        fp_out <= (mag_r == '0) ? FP_ZERO : {sign_r, exp_r, mag_r};
    end
  end

  // Datapath: only meaningful while a conversion is in progress, so no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      sign_r <= int_s[INT_W-1];
      mag_r  <= abs_mag(int_s);
      exp_r  <= EXP_INIT;
    end else if (shift) begin
      mag_r <= {mag_r[FRAC_W-2:0], 1'b0};
      exp_r <= exp_r - 1'b1;
    end
  end

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Directed bench for int_to_fp_seq: latency, results, handshake, reset abort,
// and a full 256-value round trip through a behavioural fp_to_int model.
module tb_int_to_fp_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  int_in;
  logic        ready;
  logic        done_tick;
  logic [12:0] fp_out;

  int errors = 0;
  int checks = 0;

  int_to_fp_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .int_in    (int_in),
    .ready     (ready),
    .done_tick (done_tick),
    .fp_out    (fp_out)
  );

  always #5 clk = ~clk;

  function automatic void fp_to_int_model(input logic [12:0] f, output logic [7:0] iv,
                                          output logic of, output logic uf);
    int e, m;
    e  = int'(f[11:8]);
    m  = (int'(f[7:0]) * (1 << e)) / 256;
    uf = (m == 0);
    of = f[12] ? (m > 128) : (m > 127);
    iv = f[12] ? 8'(-m) : 8'(m);
  endfunction

  function automatic int lead_zeros(input logic [7:0] v);
    int m, n;
    m = v[7] ? (256 - int'(v)) : int'(v);
    n = 0;
    if (m != 0)
      while (((m << n) & 8'h80) == 0) n++;
    return n;
  endfunction

  // Accept one request, then report the cycle of done_tick (cycle 1 = first after accept).
  task automatic convert(input logic [7:0] v, output logic [12:0] res, output int lat);
    bit busy_ok;
    busy_ok = 1'b1;
    lat = -1;
    res = 'x;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_start v=%02h: got %b want 1", v, ready);
    end
    start  = 1'b1;
    int_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    int_in = ~v;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (ready !== 1'b0) busy_ok = 1'b0;
      if (done_tick === 1'b1) begin
        lat = cyc;
        res = fp_out;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL timeout v=%02h: no done_tick within 20 cycles", v);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL ready_busy v=%02h: ready not held low up to done_tick", v);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    int_in  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || fp_out !== 13'h0000) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b fp=%04h want 1 0 0000", ready, done_tick, fp_out);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_vector(input logic [7:0] v, input logic [12:0] exp_fp, input int exp_lat);
    logic [12:0] res;
    int lat;
    convert(v, res, lat);
    checks++;
    if (res !== exp_fp) begin
      errors++;
      $display("FAIL fp_out v=%02h: got %04h want %04h", v, res, exp_fp);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency v=%02h: got %0d want %0d", v, lat, exp_lat);
    end
  endtask

  task automatic test_ignore_busy_start();
    int dones, first;
    dones = 0;
    first = -1;
    @(negedge clk);
    start  = 1'b1;
    int_in = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (done_tick === 1'b1) begin
        dones++;
        if (first < 0) first = cyc;
        checks++;
        if (fp_out !== 13'h0180) begin
          errors++;
          $display("FAIL busy_start_fp: got %04h want 0180", fp_out);
        end
      end
      start  = (cyc >= 1 && cyc <= 4);
      int_in = 8'd64;
    end
    start = 1'b0;
    checks++;
    if (dones != 1 || first != 9) begin
      errors++;
      $display("FAIL busy_start_ignored: dones=%0d first=%0d want 1 at 9", dones, first);
    end
  endtask

  task automatic test_reset_mid();
    bit spurious;
    spurious = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    int_in = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (done_tick === 1'b1) spurious = 1'b1;
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || fp_out !== 13'h0000) begin
      errors++;
      $display("FAIL reset_abort_state: ready=%b fp=%04h want 1 0000", ready, fp_out);
    end
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done_tick === 1'b1) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL reset_abort_done: got done_tick want none");
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] res;
    logic [7:0]  iv;
    logic        of, uf;
    int          lat;
    for (int i = 0; i < 256; i++) begin
      convert(8'(i), res, lat);
      fp_to_int_model(res, iv, of, uf);
      checks++;
      if (iv !== 8'(i)) begin
        errors++;
        $display("FAIL roundtrip v=%02h: fp=%04h int=%02h want %02h", i, res, iv, 8'(i));
      end
      checks++;
      if (of !== 1'b0 || uf !== (i == 0)) begin
        errors++;
        $display("FAIL flags v=%02h: of=%b uf=%b want 0 %b", i, of, uf, (i == 0));
      end
      checks++;
      if (lat != lead_zeros(8'(i)) + 2) begin
        errors++;
        $display("FAIL sweep_latency v=%02h: got %0d want %0d", i, lat, lead_zeros(8'(i)) + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector(8'd1,   13'h0180, 9);
    test_vector(8'h80,  13'h1880, 2);
    test_vector(8'd127, 13'h07FE, 3);
    test_vector(8'hFB,  13'h13A0, 7);
    test_vector(8'd0,   13'h0000, 2);
    test_ignore_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
